// File: rtl/fetch_unit.sv
// IF-stage instruction fetch engine.
// Owns the PC and issues one word read at a time to the instruction ROM, which has variable latency.
// Each returned instruction is registered into an output slot, with a one-entry skid buffer behind it.
// Branches use MIPS single delay-slot redirects.
//
// Handshake towards ID: the transfer of {id_addr, id_inst} completes on a cycle with id_valid && !stall.
// While stall=1 the presented instruction is held constant.
// branch_flag/branch_addr are only meaningful on a completing transfer.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_rvalid,
    input  logic [INST_WIDTH-1:0] rom_rdata,
    input  logic                  stall,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  id_valid,
    output logic [ADDR_WIDTH-1:0] id_addr,
    output logic [INST_WIDTH-1:0] id_inst,
    output logic                  fetch_busy
);

    // Output occupancy: slot only, or slot plus skid entry.
    localparam logic [1:0] OCC_EMPTY     = 2'd0;
    localparam logic [1:0] OCC_FULL      = 2'd1;
    localparam logic [1:0] OCC_FULL_SKID = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    logic [1:0]            occ_q, occ_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0] slot_addr_q, slot_addr_d;
    logic [INST_WIDTH-1:0] slot_inst_q, slot_inst_d;
    logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
    logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;

    logic                  slot_valid;
    logic                  skid_valid;
    logic                  accept;
    logic                  resp;
    logic                  take_branch;
    logic [ADDR_WIDTH-1:0] delay_addr;
    logic                  redirect_now;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  resp_to_skid;
    logic                  issue;

    // Handshake qualifiers, branch classification and the request-issue decision.
    always_comb begin
        slot_valid   = (occ_q != OCC_EMPTY);
        skid_valid   = (occ_q == OCC_FULL_SKID);
        accept       = !rst && slot_valid && !stall;
        // A strobe with nothing outstanding is stale (e.g. from before a reset) and is dropped.
        resp         = !rst && busy_q && rom_rvalid;
        take_branch  = accept && branch_flag;
        delay_addr   = slot_addr_q + WORD_STEP;
        // pc already moved past the delay slot: the sequential address must not be requested.
        // Any request going out now is steered straight to the target instead.
        redirect_now = take_branch && (pc_q != delay_addr);
        fetch_addr   = redirect_now ? branch_addr : pc_q;
        // A response that must park in the skid buffer leaves no room for another one.
        // Hold off issuing so that at most slot + skid instructions are ever in flight.
        resp_to_skid = resp && slot_valid && !accept;
        issue        = !rst && (!busy_q || resp) && !skid_valid && !resp_to_skid;
    end

    // Next-PC selection including delay-slot branch handling.
    always_comb begin
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_target_d = pend_target_q;
        if (issue) begin
            if (pend_q) begin
                // This request is the delay slot; the one after it goes to the target.
                pc_d   = pend_target_q;
                pend_d = 1'b0;
            end else if (take_branch && !redirect_now) begin
                // Delay slot is being requested right now.
                pc_d = branch_addr;
            end else begin
                pc_d = fetch_addr + WORD_STEP;
            end
        end else if (redirect_now) begin
            pc_d = branch_addr;
        end else if (take_branch) begin
            // Delay slot not yet requested: remember the target until it is.
            pend_d        = 1'b1;
            pend_target_d = branch_addr;
        end
    end

    // Outstanding-request tracking: a single request in flight with its fetch address.
    always_comb begin
        busy_d     = busy_q;
        req_addr_d = req_addr_q;
        if (issue) begin
            busy_d     = 1'b1;
            req_addr_d = fetch_addr;
        end else if (resp) begin
            busy_d = 1'b0;
        end
    end

    // Occupancy FSM: routes responses into the slot or skid buffer and preserves order.
    always_comb begin
        occ_d       = occ_q;
        slot_addr_d = slot_addr_q;
        slot_inst_d = slot_inst_q;
        skid_addr_d = skid_addr_q;
        skid_inst_d = skid_inst_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (resp) begin
                    occ_d       = OCC_FULL;
                    slot_addr_d = req_addr_q;
                    slot_inst_d = rom_rdata;
                end
            end
            OCC_FULL: begin
                if (resp) begin
                    if (accept) begin
                        slot_addr_d = req_addr_q;
                        slot_inst_d = rom_rdata;
                    end else begin
                        occ_d       = OCC_FULL_SKID;
                        skid_addr_d = req_addr_q;
                        skid_inst_d = rom_rdata;
                    end
                end else if (accept) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL_SKID: begin
                if (accept) begin
                    slot_addr_d = skid_addr_q;
                    slot_inst_d = skid_inst_q;
                    if (resp) begin
                        skid_addr_d = req_addr_q;
                        skid_inst_d = rom_rdata;
                    end else begin
                        occ_d = OCC_FULL;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q         <= OCC_EMPTY;
            pc_q          <= RESET_PC;
            busy_q        <= 1'b0;
            req_addr_q    <= '0;
            slot_addr_q   <= '0;
            slot_inst_q   <= '0;
            skid_addr_q   <= '0;
            skid_inst_q   <= '0;
            pend_q        <= 1'b0;
            pend_target_q <= '0;
        end else begin
            occ_q         <= occ_d;
            pc_q          <= pc_d;
            busy_q        <= busy_d;
            req_addr_q    <= req_addr_d;
            slot_addr_q   <= slot_addr_d;
            slot_inst_q   <= slot_inst_d;
            skid_addr_q   <= skid_addr_d;
            skid_inst_q   <= skid_inst_d;
            pend_q        <= pend_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign rom_en     = issue;
    assign rom_addr   = rst ? RESET_PC : fetch_addr;
    assign id_valid   = slot_valid && !rst;
    assign id_addr    = id_valid ? slot_addr_q : '0;
    assign id_inst    = id_valid ? slot_inst_q : '0;
    assign fetch_busy = busy_q && !rst;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// A combined ROM model and monitor process pops expected request and delivery queues.
// The main process drives reset, stall and branch per scenario.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    typedef logic [31:0] vec8_t [8];

    logic        clk;
    logic        rst;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_rvalid;
    logic [31:0] rom_rdata;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        id_valid;
    logic [31:0] id_addr;
    logic [31:0] id_inst;
    logic        fetch_busy;

    logic [31:0] exp_req_q[$];
    logic [31:0] exp_q[$];

    int          lat = 1;
    logic [31:0] forbid = 32'h0000_0001;
    int          timeouts = 0;
    int          checks = 0;
    int          errors = 0;

    // ROM model / monitor state
    bit          rom_pend = 0;
    int          rom_cnt = 0;
    logic [31:0] rom_paddr = '0;
    bit          stale = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_inst = '0;
    int          seen_to = 0;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_rvalid (rom_rvalid),
        .rom_rdata  (rom_rdata),
        .stall      (stall),
        .branch_flag(branch_flag),
        .branch_addr(branch_addr),
        .id_valid   (id_valid),
        .id_addr    (id_addr),
        .id_inst    (id_inst),
        .fetch_busy (fetch_busy)
    );

    // ROM contents: a fixed scramble of the address.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ROM model and scoreboard monitor: samples at negedge, drives ROM response just after posedge.
    initial begin
        logic [31:0] e;
        rom_rvalid = 1'b0;
        rom_rdata  = '0;
        forever begin
            @(negedge clk);
            if (timeouts != seen_to) begin
                seen_to = timeouts;
                chk("drain_timeout", 0, 1);
            end
            if (rst) begin
                chk("reset_outputs", {rom_en, id_valid, fetch_busy, id_addr, id_inst, rom_addr},
                    {3'b000, 32'h0, 32'h0, RESET_PC});
                if (rom_pend) stale = 1;
                rom_pend   = 0;
                cyc        = 0;
                prev_stall = 0;
            end else begin
                if (cyc == lat)     chk("first_valid_early", id_valid, 0);
                if (cyc == lat + 1) chk("first_valid_late", id_valid, 1);
                if (rom_pend)       chk("busy_while_waiting", fetch_busy, 1);
                if (stall)          chk("no_issue_when_stalled", rom_en, 0);
                if (stall && prev_stall)
                    chk("frozen_output", {id_valid, id_addr, id_inst}, {1'b1, prev_addr, prev_inst});
                if (rom_en) begin
                    chk("single_outstanding", rom_pend, 0);
                    chk("forbidden_addr", rom_addr == forbid, 0);
                    if (exp_req_q.size() > 0) chk("rom_addr", rom_addr, exp_req_q.pop_front());
                    rom_pend  = 1;
                    rom_cnt   = lat;
                    rom_paddr = rom_addr;
                end
                if (id_valid && !stall && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("id_addr_inst", {id_addr, id_inst}, {e, inst_of(e)});
                end
                prev_stall = stall;
                prev_addr  = id_addr;
                prev_inst  = id_inst;
                cyc++;
            end
            @(posedge clk);
            #1;
            rom_rvalid = 1'b0;
            rom_rdata  = '0;
            if (stale) begin
                rom_rvalid = 1'b1;
                rom_rdata  = 32'hDEADBEEF;
                stale      = 0;
            end else if (rom_pend) begin
                rom_cnt--;
                if (rom_cnt == 0) begin
                    rom_rvalid = 1'b1;
                    rom_rdata  = inst_of(rom_paddr);
                    rom_pend   = 0;
                end
            end
        end
    end

    task automatic start_reset();
        @(posedge clk);
        #1;
        rst         = 1'b1;
        stall       = 1'b0;
        branch_flag = 1'b0;
        branch_addr = '0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input vec8_t r, input int nr, input vec8_t o, input int no);
        exp_req_q.delete();
        exp_q.delete();
        for (int i = 0; i < nr; i++) exp_req_q.push_back(r[i]);
        for (int i = 0; i < no; i++) exp_q.push_back(o[i]);
    endtask

    // Drives stall/branch each cycle until both expected queues drain (bounded).
    task automatic drive(input logic [31:0] st_a, input int st_n,
                         input logic [31:0] br_x, input logic [31:0] br_t);
        int st_left;
        bit st_done;
        bit br_done;
        bit done;
        st_left = 0;
        st_done = 0;
        br_done = 0;
        done    = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            branch_flag = 1'b0;
            branch_addr = '0;
            if (!st_done && id_valid && id_addr == st_a) begin
                st_left = st_n;
                st_done = 1;
            end
            stall = (st_left > 0);
            if (st_left > 0) st_left--;
            if (stall || !id_valid) begin
                // Unqualified branch requests must be ignored.
                branch_flag = 1'b1;
                branch_addr = 32'h1234_5670;
            end else if (!br_done && id_addr == br_x) begin
                branch_flag = 1'b1;
                branch_addr = br_t;
                br_done     = 1;
            end
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && exp_req_q.size() == 0) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        stall       = 1'b0;
        branch_flag = 1'b0;
        if (!done) timeouts++;
    endtask

    // Stimulus
    initial begin
        vec8_t req_a;
        vec8_t out_a;
        vec8_t req_c;
        vec8_t out_c;
        vec8_t seq_d;
        rst         = 1'b1;
        stall       = 1'b0;
        branch_flag = 1'b0;
        branch_addr = '0;
        req_a = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
                  32'hBFC00010, 32'hBFC00014, 32'hBFC00100, 32'hBFC00104};
        out_a = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
                  32'hBFC00010, 32'hBFC00014, 32'hBFC00100, 32'h0};
        req_c = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
                  32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
        out_c = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C,
                  32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h0};
        seq_d = '{32'hBFC00000, 32'hBFC00004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        // Latency 1: streaming, 4-cycle stall at BFC00004, branch at BFC00010 to BFC00100.
        start_reset();
        lat    = 1;
        forbid = 32'hBFC00018;
        load(req_a, 8, out_a, 7);
        release_reset();
        drive(32'hBFC00004, 4, 32'hBFC00010, 32'hBFC00100);

        // Latency 3: branch at BFC00010 while its delay slot is already in flight.
        start_reset();
        lat    = 3;
        forbid = 32'hBFC00018;
        load(req_a, 8, out_a, 7);
        release_reset();
        drive(32'h0000_0001, 0, 32'hBFC00010, 32'hBFC00100);

        // Latency 1: branch at BFC00008 into the top of the address space; pc wraps to 0.
        start_reset();
        lat    = 1;
        forbid = 32'hBFC00010;
        load(req_c, 8, out_c, 7);
        release_reset();
        drive(32'hBFC00004, 4, 32'hBFC00008, 32'hFFFFFFF8);

        // Latency 3: one-cycle reset mid-request, then a stale response.
        start_reset();
        lat    = 3;
        forbid = 32'h0000_0001;
        release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        load(seq_d, 2, seq_d, 2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(32'h0000_0001, 0, 32'h0000_0001, 32'h0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
